// File: rtl/calc_pkg.sv
// Shared opcode/state encodings for the calc_sequencer slice.
// Opcode field sits in the top OPC_W bits of every instruction word.
package calc_pkg;

  localparam int OPC_W = 2;

  typedef enum logic [OPC_W-1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_AND = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    LOAD  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10
  } state_e;

endpackage

// File: rtl/calc_alu.sv
// Combinational 4-op ALU on unsigned operands; zero latency, no flow control.
// SUB reports magnitude plus a sign flag instead of a two's-complement result.
module calc_alu
  import calc_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [OPC_W-1:0]    op,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic [2*DATA_W-1:0] result,
  output logic                neg
);

  logic [2*DATA_W-1:0] a_ext;
  logic [2*DATA_W-1:0] b_ext;

  assign a_ext = {{DATA_W{1'b0}}, a};
  assign b_ext = {{DATA_W{1'b0}}, b};

  always_comb begin
    result = '0;
    neg    = 1'b0;
    case (op)
      OP_ADD: result = a_ext + b_ext;
      OP_SUB: begin
        if (a >= b) begin
          result = a_ext - b_ext;
        end else begin
          result = b_ext - a_ext;
          neg    = 1'b1;
        end
      end
      OP_MUL: result = a_ext * b_ext;
      OP_AND: result = {{DATA_W{1'b0}}, a & b};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/calc_sequencer.sv
// Loads up to DEPTH instructions, then streams one registered ALU result per instruction.
// First result valid two edges after start; output register holds while res_ready is low.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int DEPTH   = 16,
  localparam int CNT_W   = $clog2(DEPTH + 1),
  localparam int INSTR_W = OPC_W + 2 * DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [INSTR_W-1:0]  DIN,
  input  logic                din_valid,
  output logic                din_ready,
  input  logic                start,
  output logic [2*DATA_W-1:0] RESULT,
  output logic                NEG,
  output logic                res_valid,
  input  logic                res_ready,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    prog_len
);

  localparam int              AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    prog_len_q, prog_len_d;
  logic [CNT_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic                fetch_q, fetch_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                neg_q, neg_d;
  logic                res_valid_q, res_valid_d;
  logic                done_q, done_d;

  logic [INSTR_W-1:0]  mem_q [DEPTH];
  logic [INSTR_W-1:0]  instr;
  logic [2*DATA_W-1:0] alu_result;
  logic                alu_neg;
  logic                wr_en;
  logic                issue;

  assign instr = mem_q[rd_ptr_q[AW-1:0]];

  calc_alu #(.DATA_W(DATA_W)) u_alu (
    .op    (instr[INSTR_W-1 -: OPC_W]),
    .a     (instr[2*DATA_W-1 -: DATA_W]),
    .b     (instr[DATA_W-1:0]),
    .result(alu_result),
    .neg   (alu_neg)
  );

  always_comb begin
    state_d     = state_q;
    prog_len_d  = prog_len_q;
    rd_ptr_d    = rd_ptr_q;
    fetch_d     = 1'b0;
    result_d    = result_q;
    neg_d       = neg_q;
    res_valid_d = res_valid_q;
    done_d      = 1'b0;
    din_ready   = 1'b0;
    wr_en       = 1'b0;
    issue       = 1'b0;

    case (state_q)
      LOAD: begin
        din_ready = (prog_len_q < DEPTH_C);
        wr_en     = din_valid && din_ready;
        if (wr_en) begin
          prog_len_d = prog_len_q + CNT_W'(1);
        end
        // A write landing with start joins the program being launched.
        if (start && ((prog_len_q != '0) || wr_en)) begin
          state_d  = RUN;
          rd_ptr_d = '0;
          fetch_d  = 1'b1;
        end
      end
      RUN: begin
        // The first RUN cycle is a dead fetch slot, giving start-to-valid of two edges.
        issue = !fetch_q && (!res_valid_q || res_ready);
        if (issue) begin
          result_d    = alu_result;
          neg_d       = alu_neg;
          res_valid_d = 1'b1;
          rd_ptr_d    = rd_ptr_q + CNT_W'(1);
          if ((rd_ptr_q + CNT_W'(1)) == prog_len_q) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          done_d      = 1'b1;
          prog_len_d  = '0;
          state_d     = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LOAD;
      prog_len_q  <= '0;
      rd_ptr_q    <= '0;
      fetch_q     <= 1'b0;
      result_q    <= '0;
      neg_q       <= 1'b0;
      res_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      prog_len_q  <= prog_len_d;
      rd_ptr_q    <= rd_ptr_d;
      fetch_q     <= fetch_d;
      result_q    <= result_d;
      neg_q       <= neg_d;
      res_valid_q <= res_valid_d;
      done_q      <= done_d;
    end
  end

  // Program memory is deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem_q[prog_len_q[AW-1:0]] <= DIN;
    end
  end

  assign RESULT    = result_q;
  assign NEG       = neg_q;
  assign res_valid = res_valid_q;
  assign done      = done_q;
  assign prog_len  = prog_len_q;
  assign busy      = (state_q == RUN) || (state_q == DRAIN);

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed + randomized bench for calc_sequencer (DATA_W=8, DEPTH=16).
// Expected results come from a queue of loaded words evaluated with plain arithmetic.
module tb_calc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [17:0] DIN;
  logic        din_valid;
  logic        din_ready;
  logic        start;
  logic [15:0] RESULT;
  logic        NEG;
  logic        res_valid;
  logic        res_ready;
  logic        busy;
  logic        done;
  logic [4:0]  prog_len;

  int vectors     = 0;
  int miscompares = 0;
  logic [17:0] prog[$];

  always #5 clk = ~clk;

  calc_sequencer #(.DATA_W(8), .DEPTH(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .DIN      (DIN),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .start    (start),
    .RESULT   (RESULT),
    .NEG      (NEG),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .busy     (busy),
    .done     (done),
    .prog_len (prog_len)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] mkw(input int op, input int a, input int b);
    logic [1:0] o;
    logic [7:0] x;
    logic [7:0] y;
    o = 2'(op);
    x = 8'(a);
    y = 8'(b);
    return {o, x, y};
  endfunction

  // Reference: unsigned arithmetic on the operand fields of one word.
  function automatic void ref_alu(input logic [17:0] w, output logic [15:0] r, output logic n);
    int a;
    int b;
    a = int'(w[15:8]);
    b = int'(w[7:0]);
    n = 1'b0;
    case (w[17:16])
      2'd0: r = 16'(a + b);
      2'd1: begin
        if (a >= b) r = 16'(a - b);
        else begin
          r = 16'(b - a);
          n = 1'b1;
        end
      end
      2'd2: r = 16'(a * b);
      default: r = 16'(a & b);
    endcase
  endfunction

  task automatic push_word(input logic [17:0] w, input bit with_start);
    bit acc;
    DIN       = w;
    din_valid = 1'b1;
    start     = with_start;
    acc       = (prog.size() < 16);
    chk("din_ready", din_ready, acc);
    if (acc) prog.push_back(w);
    cyc();
    din_valid = 1'b0;
    start     = 1'b0;
    chk("prog_len", prog_len, prog.size());
  endtask

  // mode 0: ready always high; 1: random ready; 2: three stall cycles on the second result.
  task automatic run_prog(input int mode, input bit started, input int stop_after);
    int got    = 0;
    int budget = 400;
    int stall  = 0;
    logic [15:0] er;
    logic        en;
    bit          rdy;
    res_ready = 1'b0;
    if (!started) begin
      start = 1'b1;
      cyc();
      start = 1'b0;
    end
    chk("busy_after_start", busy, 1);
    chk("valid_edge_t", res_valid, 0);
    cyc();
    chk("valid_edge_t1", res_valid, 0);
    cyc();
    chk("valid_edge_t2", res_valid, 1);
    while (got < prog.size() && budget > 0) begin
      case (mode)
        0: rdy = 1'b1;
        1: rdy = ($urandom_range(0, 3) != 0);
        default: rdy = !(got == 1 && stall < 3);
      endcase
      res_ready = rdy;
      if (mode == 0) chk("stream_valid", res_valid, 1);
      if (res_valid) begin
        ref_alu(prog[got], er, en);
        chk("result", RESULT, er);
        chk("neg", NEG, en);
        if (rdy) got++;
        else stall++;
      end
      cyc();
      budget--;
      if (stop_after != 0 && got == stop_after) begin
        res_ready = 1'b0;
        return;
      end
    end
    chk("result_count", got, prog.size());
    if (mode == 2) chk("stall_cycles", stall, 3);
    res_ready = 1'b0;
    chk("done_pulse", done, 1);
    chk("prog_len_clear", prog_len, 0);
    chk("busy_end", busy, 0);
    chk("valid_end", res_valid, 0);
    cyc();
    chk("done_low", done, 0);
    chk("din_ready_end", din_ready, 1);
    prog.delete();
  endtask

  initial begin
    #500000;
    $fatal(1, "FAIL watchdog: simulation did not finish");
  end

  initial begin
    bit co;
    int len;
    reset     = 1'b1;
    DIN       = '0;
    din_valid = 1'b0;
    start     = 1'b0;
    res_ready = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_result", RESULT, 0);
    chk("rst_neg", NEG, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_prog_len", prog_len, 0);
    chk("rst_din_ready", din_ready, 1);

    // Basic three-instruction program.
    push_word(mkw(0, 5, 3), 1'b0);
    push_word(mkw(1, 3, 5), 1'b0);
    push_word(mkw(2, 255, 255), 1'b0);
    run_prog(0, 1'b0, 0);

    // Overfill: 17th word must be refused.
    for (int i = 0; i < 17; i++) push_word(18'($urandom), 1'b0);
    run_prog(1, 1'b0, 0);

    // Backpressure hold mid-run.
    for (int i = 0; i < 6; i++) push_word(18'($urandom), 1'b0);
    run_prog(2, 1'b0, 0);

    // Start on an empty program is ignored.
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("empty_busy", busy, 0);
    chk("empty_valid", res_valid, 0);
    chk("empty_done", done, 0);
    chk("empty_prog_len", prog_len, 0);
    cyc();
    chk("empty_busy2", busy, 0);
    chk("empty_valid2", res_valid, 0);
    chk("empty_din_ready", din_ready, 1);

    // Reset mid-run after the second result.
    for (int i = 0; i < 5; i++) push_word(18'($urandom), 1'b0);
    run_prog(0, 1'b0, 2);
    reset     = 1'b1;
    res_ready = 1'b1;
    cyc();
    reset     = 1'b0;
    res_ready = 1'b0;
    prog.delete();
    chk("mid_rst_valid", res_valid, 0);
    chk("mid_rst_result", RESULT, 0);
    chk("mid_rst_neg", NEG, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_din_ready", din_ready, 1);
    chk("mid_rst_prog_len", prog_len, 0);
    chk("mid_rst_done", done, 0);

    // Start coinciding with the final write.
    push_word(mkw(1, 7, 7), 1'b0);
    push_word(mkw(3, 'hF0, 'h3C), 1'b1);
    run_prog(0, 1'b1, 0);

    // Random programs, random backpressure, random start alignment.
    for (int t = 0; t < 5; t++) begin
      len = $urandom_range(1, 16);
      co  = 1'($urandom_range(0, 1));
      for (int i = 0; i < len; i++) push_word(18'($urandom), (i == len - 1) && co);
      run_prog(1, co, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
